param_fifo: RTL

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 22 ++
 rtl/param_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: ceiling-log2 width function and default parameter constants.
package fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer counting 0..DEPTH-1; advances one step per edge while inc is high.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO, one-edge registered read; full drops pushes and empty ignores pops,
// each raising a sticky error flag until clear_err or reset.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CW      = clog2(DEPTH + 1),
  localparam int PW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             pop_ok;
  logic             push_ok;

  // A pop on a full FIFO frees a slot on the same edge, so the push may proceed.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  fifo_ptr #(.DEPTH(DEPTH)) u_wp (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wp)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rp (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rp)
  );

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rp];
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // A new error on the same edge as clear_err takes priority, keeping the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop_ok) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
